// File: rtl/interrupt_controller.sv
// Prioritised, vectored interrupt controller: latches requests, presents the lowest pending+enabled index, pulses irq_clear on ack.
// Request latency 2 clocks from irq_in; define INTC_EDGE_EN for rising-edge pending instead of level.
module interrupt_controller #(
    parameter int SOURCES     = 8,
    parameter int VECTOR_BITS = 3
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   nwr,
    input  logic [1:0]             address,
    input  logic [SOURCES-1:0]     data_in,
    output logic [SOURCES-1:0]     data_out,
    input  logic [SOURCES-1:0]     irq_in,
    output logic [SOURCES-1:0]     irq_clear,
    output logic                   cpu_irq,
    output logic [VECTOR_BITS-1:0] cpu_vector,
    input  logic                   cpu_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CLEAR,
        S_SETTLE
    } state_t;

    state_t                 state_q, state_d;
    logic [SOURCES-1:0]     mask_q, mask_d;
    logic [SOURCES-1:0]     pending_q, pending_d;
    logic [SOURCES-1:0]     irq_clear_q, irq_clear_d;
    logic                   cpu_irq_q, cpu_irq_d;
    logic [VECTOR_BITS-1:0] vec_q, vec_d;

    logic [SOURCES-1:0]     masked;
    logic [SOURCES-1:0]     vec_onehot;
    logic [SOURCES-1:0]     holdoff;
    logic [SOURCES-1:0]     set_req;
    logic [SOURCES-1:0]     wr_clear;
    logic [SOURCES-1:0]     ack_clear;
    logic                   any_masked;
    logic [VECTOR_BITS-1:0] lowest_idx;

    assign masked     = pending_q & mask_q;
    assign any_masked = |masked;

    // Scan downwards so the lowest set index is the one left standing.
    always_comb begin
        lowest_idx = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (masked[i]) begin
                lowest_idx = VECTOR_BITS'(i);
            end
        end
    end

    always_comb begin
        vec_onehot = '0;
        for (int i = 0; i < SOURCES; i++) begin
            vec_onehot[i] = (vec_q == VECTOR_BITS'(i));
        end
    end

    // The acknowledged source is blind for two cycles while its own clear takes effect.
    assign holdoff   = (state_q == S_CLEAR || state_q == S_SETTLE) ? vec_onehot : '0;
    assign wr_clear  = (!nwr && address == 2'd2) ? data_in : '0;
    assign ack_clear = (state_q == S_REQ && cpu_ack) ? vec_onehot : '0;

`ifdef INTC_EDGE_EN
    logic [SOURCES-1:0] prev_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prev_q <= '0;
        end else begin
            prev_q <= irq_in;
        end
    end

    assign set_req = irq_in & ~prev_q & ~holdoff;
`else
    assign set_req = irq_in & ~holdoff;
`endif

    // A new set beats a CLEAR write, but the acknowledge of the serviced bit beats both.
    assign pending_d = ((pending_q & ~wr_clear) | set_req) & ~ack_clear;
    assign mask_d    = (!nwr && address == 2'd0) ? data_in : mask_q;

    always_comb begin
        state_d     = state_q;
        cpu_irq_d   = cpu_irq_q;
        vec_d       = vec_q;
        irq_clear_d = '0;
        case (state_q)
            S_IDLE: begin
                if (any_masked) begin
                    cpu_irq_d = 1'b1;
                    vec_d     = lowest_idx;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (cpu_ack) begin
                    cpu_irq_d   = 1'b0;
                    irq_clear_d = vec_onehot;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            pending_q   <= '0;
            irq_clear_q <= '0;
            cpu_irq_q   <= 1'b0;
            vec_q       <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            irq_clear_q <= irq_clear_d;
            cpu_irq_q   <= cpu_irq_d;
            vec_q       <= vec_d;
        end
    end

    always_comb begin
        case (address)
            2'd0:    data_out = mask_q;
            2'd1:    data_out = pending_q;
            default: data_out = '0;
        endcase
    end

    assign irq_clear  = irq_clear_q;
    assign cpu_irq    = cpu_irq_q;
    assign cpu_vector = vec_q;

endmodule
